reg_ctrl_master: RTL and testbench



---
 rtl/reg_ctrl_master.sv | 165 ++++++++++++++++
 tb/tb_reg_ctrl_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctrl_master
// Description : Register-control bus initiator. Takes one command at a time on
//               a valid/ready port, drives sel/wr/addr/wdata to the register
//               block, waits out the read recovery cycle, and returns the
//               result on a valid/ready response port. A timeout converts a
//               responder that never raises ready into an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_ctrl_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sel,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Counter must be able to hold TIMEOUT; it is compared against TIMEOUT-1
  // so that the edge that would reach TIMEOUT is the one that gives up.
  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  sel_nx, wr_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic                  rsp_valid_nx, rsp_wr_nx, rsp_err_nx;
  logic [DATA_WIDTH-1:0] rsp_rdata_nx;
  logic                  timeout_hit;

  assign timeout_hit = (cnt == CNT_LAST);

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nx = S_REQ;
      S_REQ: begin
        if (ready)            state_nx = wr ? S_RESP : S_RDWAIT;
        else if (timeout_hit) state_nx = S_RESP;
      end
      S_RDWAIT: state_nx = S_RESP;
      S_RESP:   if (rsp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output decode: command handshake plus next values for registered outputs.
  // The latched command type lives in wr while in REQ, so it doubles as the
  // type echoed on a timeout.
  always_comb begin
    cmd_ready    = (state == S_IDLE);
    sel_nx       = sel;
    wr_nx        = wr;
    addr_nx      = addr;
    wdata_nx     = wdata;
    rsp_valid_nx = rsp_valid;
    rsp_wr_nx    = rsp_wr;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    cnt_nx       = cnt;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          sel_nx   = 1'b1;
          wr_nx    = cmd_wr;
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          cnt_nx   = '0;
        end
      end
      S_REQ: begin
        if (ready) begin
          if (wr) begin
            sel_nx       = 1'b0;
            wr_nx        = 1'b0;
            rsp_valid_nx = 1'b1;
            rsp_wr_nx    = 1'b1;
            rsp_rdata_nx = '0;
            rsp_err_nx   = 1'b0;
          end
        end else if (timeout_hit) begin
          sel_nx       = 1'b0;
          wr_nx        = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_wr_nx    = wr;
          rsp_rdata_nx = '0;
          rsp_err_nx   = 1'b1;
          cnt_nx       = cnt + CNT_W'(1);
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_RDWAIT: begin
        // Read data is valid only now; the responder's ready dip is ignored.
        sel_nx       = 1'b0;
        rsp_valid_nx = 1'b1;
        rsp_wr_nx    = 1'b0;
        rsp_rdata_nx = rdata;
        rsp_err_nx   = 1'b0;
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_nx = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel       <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      sel       <= sel_nx;
      wr        <= wr_nx;
      addr      <= addr_nx;
      wdata     <= wdata_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_wr    <= rsp_wr_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      cnt       <= cnt_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_ctrl_master
// Description : Directed self-checking bench for reg_ctrl_master with a small
//               register-block responder model (one-cycle ready dip on reads).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_ctrl_master;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_wr;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sel, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  int n_checks = 0;
  int n_errors = 0;

  reg_ctrl_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  // Responder model: register file, 0x05 resets to 0x1234, ready dips for
  // one cycle after each accepted read, read data valid in that cycle.
  logic          force_nrdy = 1'b0;
  logic          rd_gap;
  logic [DW-1:0] mem [0:255];
  assign ready = ~force_nrdy & ~rd_gap;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_gap <= 1'b0;
      rdata  <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= (i == 5) ? 16'h1234 : 16'h0000;
    end else begin
      rd_gap <= 1'b0;
      if (sel && ready) begin
        if (wr) mem[addr] <= wdata;
        else begin
          rd_gap <= 1'b1;
          rdata  <= mem[addr];
        end
      end
    end
  end

  // Cycle counter and command-acceptance log.
  int cyc = 0;
  int acc_n = 0;
  int acc_log [0:15];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_log[acc_n[3:0]] <= cyc;
      acc_n <= acc_n + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  // Wait (bounded) until rsp_valid is seen at a negedge.
  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk_eq("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    issue(1'b0, a, '0);
    wait_rsp();
    chk_eq(tag, 32'(rsp_rdata), 32'(exp));
    chk_eq({tag, "_err"}, 32'(rsp_err), 32'd0);
    accept_rsp();
  endtask

  initial begin
    int sel_cnt;
    int a0;
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel_cnt;
    int a0;
    int wguard;

    // Reset state
    #12;
    chk_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_eq("rst_sel", 32'(sel), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_addr", 32'(addr), 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // 1. Write 0x10 = 0xBEEF
    issue(1'b1, 8'h10, 16'hBEEF);
    chk_eq("w_sel", 32'(sel), 32'd1);
    chk_eq("w_wr", 32'(wr), 32'd1);
    chk_eq("w_addr", 32'(addr), 32'h10);
    chk_eq("w_wdata", 32'(wdata), 32'hBEEF);
    chk_eq("w_cmd_ready", 32'(cmd_ready), 32'd0);
    chk_eq("w_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk_eq("w_sel_drop", 32'(sel), 32'd0);
    chk_eq("w_rsp_valid", 32'(rsp_valid), 32'd1);
    chk_eq("w_rsp_wr", 32'(rsp_wr), 32'd1);
    chk_eq("w_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("w_rsp_rdata", 32'(rsp_rdata), 32'd0);
    accept_rsp();
    chk_eq("w_rsp_clr", 32'(rsp_valid), 32'd0);
    chk_eq("w_cmd_ready2", 32'(cmd_ready), 32'd1);

    // 2. Read 0x05 from reset contents, then write/read 0x10
    issue(1'b0, 8'h05, 16'hFFFF);
    chk_eq("r_sel1", 32'(sel), 32'd1);
    chk_eq("r_wr1", 32'(wr), 32'd0);
    chk_eq("r_addr", 32'(addr), 32'h05);
    @(negedge clk);
    chk_eq("r_sel2", 32'(sel), 32'd1);
    chk_eq("r_wr2", 32'(wr), 32'd0);
    chk_eq("r_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk_eq("r_rsp_valid", 32'(rsp_valid), 32'd1);
    chk_eq("r_sel_drop", 32'(sel), 32'd0);
    chk_eq("r_rdata", 32'(rsp_rdata), 32'h1234);
    chk_eq("r_rsp_wr", 32'(rsp_wr), 32'd0);
    chk_eq("r_rsp_err", 32'(rsp_err), 32'd0);
    accept_rsp();
    issue(1'b1, 8'h10, 16'hBEEF);
    wait_rsp();
    accept_rsp();
    read_expect("r_beef", 8'h10, 16'hBEEF);

    // 3. Response backpressure
    issue(1'b0, 8'h10, '0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp_valid", 32'(rsp_valid), 32'd1);
      chk_eq("bp_rdata", 32'(rsp_rdata), 32'hBEEF);
      chk_eq("bp_rsp_wr", 32'(rsp_wr), 32'd0);
      chk_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk_eq("bp_sel", 32'(sel), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_eq("bp_clr", 32'(rsp_valid), 32'd0);
    chk_eq("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // 4. Timeout with responder stuck not-ready (TIMEOUT=4)
    force_nrdy = 1'b1;
    issue(1'b1, 8'h30, 16'h5555);
    sel_cnt = 0;
    while (sel && sel_cnt < 20) begin
      sel_cnt++;
      @(negedge clk);
    end
    chk_eq("to_sel_cycles", 32'(sel_cnt), 32'd4);
    chk_eq("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk_eq("to_rsp_err", 32'(rsp_err), 32'd1);
    chk_eq("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk_eq("to_rsp_wr", 32'(rsp_wr), 32'd1);
    accept_rsp();
    force_nrdy = 1'b0;

    // 5. Reset during RDWAIT
    issue(1'b0, 8'h05, '0);
    @(negedge clk);
    chk_eq("rr_in_rdwait", 32'(sel), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk_eq("rr_sel_async", 32'(sel), 32'd0);
    chk_eq("rr_rsp_async", 32'(rsp_valid), 32'd0);
    chk_eq("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_eq("rr_no_rsp", 32'(rsp_valid), 32'd0);
    read_expect("rr_read", 8'h05, 16'h1234);

    // 6. Back-to-back with rsp_ready tied high
    rsp_ready = 1'b1;
    a0 = acc_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h20; cmd_wdata = 16'h0A0A;
    wguard = 0;
    while (acc_n == a0 && wguard < 20) begin @(negedge clk); wguard++; end
    cmd_wr = 1'b0; cmd_wdata = '0;
    wguard = 0;
    while (acc_n < a0 + 2 && wguard < 20) begin @(negedge clk); wguard++; end
    cmd_valid = 1'b0;
    chk_eq("b2b_accepts", 32'(acc_n - a0), 32'd2);
    chk_eq("b2b_spacing", 32'(acc_log[(a0 + 1) % 16] - acc_log[a0 % 16]), 32'd3);
    wait_rsp();
    chk_eq("b2b_rdata", 32'(rsp_rdata), 32'h0A0A);
    chk_eq("b2b_rsp_wr", 32'(rsp_wr), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
